// File: rtl/usb_crc_checker_pkg.sv
// usb_crc_pkg: shared constants and types for the USB receive CRC checker.
//   POLY5 / POLY16    : generator polynomials, implicit top term dropped
//   RESID5 / RESID16  : LFSR contents after a good packet, CRC field included
//   TOKEN_BITS        : body length of a CRC5 token (11 bits of fields + 5 CRC bits)
//   DATA_MIN_BITS     : body length of an empty data packet (the 16-bit CRC only)
//   crc_chk_state_t   : checker FSM state
package usb_crc_pkg;

    localparam logic [4:0]  POLY5   = 5'b00101;
    localparam logic [15:0] POLY16  = 16'h8005;
    localparam logic [4:0]  RESID5  = 5'b01100;
    localparam logic [15:0] RESID16 = 16'h800D;

    localparam int unsigned TOKEN_BITS    = 16;
    localparam int unsigned DATA_MIN_BITS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } crc_chk_state_t;

endpackage

// File: rtl/usb_crc_checker_if.sv
// usb_crc_checker_if: the bit stream coming in and the result signals going out.
//   start, is_data, bit_valid, in_bit, pkt_end : from the receive deserializer
//   busy, done, crc_ok, crc_err, len_err       : to the packet-decoding FSM
//   bit_count [CW-1:0]                         : bits accepted in the current packet
// master = stream source / result consumer, slave = the checker.
interface usb_crc_checker_if #(
    parameter int unsigned CW = 10
);
    logic          start;
    logic          is_data;
    logic          bit_valid;
    logic          in_bit;
    logic          pkt_end;
    logic          busy;
    logic          done;
    logic          crc_ok;
    logic          crc_err;
    logic          len_err;
    logic [CW-1:0] bit_count;

    modport master (
        output start, is_data, bit_valid, in_bit, pkt_end,
        input  busy, done, crc_ok, crc_err, len_err, bit_count
    );

    modport slave (
        input  start, is_data, bit_valid, in_bit, pkt_end,
        output busy, done, crc_ok, crc_err, len_err, bit_count
    );
endinterface

// File: rtl/usb_crc_checker_lfsr.sv
// crc_lfsr: bit-serial CRC LFSR, MSB-side feedback.
//   clk_i, rst_n_i : clock, asynchronous active-low reset (register -> all ones)
//   init_i         : reload all ones this cycle
//   en_i           : shift bit_i in this cycle (applied after any reload)
//   bit_i          : serial input bit
//   crc_o          : current register contents
module crc_lfsr #(
    parameter int unsigned W    = 5,
    parameter logic [W-1:0] POLY = '0
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         init_i,
    input  logic         en_i,
    input  logic         bit_i,
    output logic [W-1:0] crc_o
);
    logic [W-1:0] crc_q;
    logic [W-1:0] crc_d;
    logic [W-1:0] base;
    logic         fb;

    // A reload and a shift may occur in the same cycle: the bit is applied
    // to the freshly loaded all-ones value, not to the stale register.
    always_comb begin
        base  = init_i ? '1 : crc_q;
        fb    = bit_i ^ base[W-1];
        crc_d = base;
        if (en_i) begin
            crc_d = {base[W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_q <= '1;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;
endmodule

// File: rtl/usb_crc_checker.sv
// usb_crc_checker: receive-side USB CRC and length checker.
//   clock, reset_n : clock, asynchronous active-low reset
//   bus (slave)    : serial packet body in; busy/done/crc_ok/crc_err/len_err
//                    and bit_count out. Flags are valid from the done pulse
//                    and held until the next start.
//   MAX_DATA_BYTES : largest legal data payload of a CRC16 packet
module usb_crc_checker
    import usb_crc_pkg::*;
#(
    parameter int unsigned MAX_DATA_BYTES = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    usb_crc_checker_if.slave  bus
);
    localparam int unsigned CW = $clog2((MAX_DATA_BYTES + 2) * 8 + 2);

    localparam logic [CW-1:0] CNT_MAX      = '1;
    localparam logic [CW-1:0] TOKEN_LEN    = CW'(TOKEN_BITS);
    localparam logic [CW-1:0] DATA_MIN_LEN = CW'(DATA_MIN_BITS);
    localparam logic [CW-1:0] DATA_MAX_LEN = CW'(DATA_MIN_BITS + 8 * MAX_DATA_BYTES);

    crc_chk_state_t state_q, state_d;
    logic           is_data_q, is_data_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           held_q, held_d;

    logic           lfsr_en;
    logic [4:0]     crc5;
    logic [15:0]    crc16;
    logic           resid_good;
    logic           len_ok;

    assign lfsr_en = bus.bit_valid && (bus.start || (state_q == RUN));

    crc_lfsr #(.W(5), .POLY(POLY5)) u_lfsr5 (
        .clk_i   (clock),
        .rst_n_i (reset_n),
        .init_i  (bus.start),
        .en_i    (lfsr_en),
        .bit_i   (bus.in_bit),
        .crc_o   (crc5)
    );

    crc_lfsr #(.W(16), .POLY(POLY16)) u_lfsr16 (
        .clk_i   (clock),
        .rst_n_i (reset_n),
        .init_i  (bus.start),
        .en_i    (lfsr_en),
        .bit_i   (bus.in_bit),
        .crc_o   (crc16)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start overrides everything, including a concurrent pkt_end
    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                RUN:     state_d = bus.pkt_end ? DONE : RUN;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Packet context: type, saturating bit count, result-held flag
    always_comb begin
        is_data_d = is_data_q;
        cnt_d     = cnt_q;
        held_d    = held_q;
        if (bus.start) begin
            is_data_d = bus.is_data;
            cnt_d     = CW'(bus.bit_valid);
            held_d    = 1'b0;
        end else if (state_q == RUN) begin
            if (bus.bit_valid && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (bus.pkt_end) begin
                held_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            is_data_q <= 1'b0;
            cnt_q     <= '0;
            held_q    <= 1'b0;
        end else begin
            is_data_q <= is_data_d;
            cnt_q     <= cnt_d;
            held_q    <= held_d;
        end
    end

    // The LFSRs and bit count are frozen outside RUN, so the verdict can be
    // derived from them directly and stays stable until the next start.
    always_comb begin
        resid_good = is_data_q ? (crc16 == RESID16) : (crc5 == RESID5);
        if (is_data_q) begin
            len_ok = (cnt_q >= DATA_MIN_LEN) && (cnt_q <= DATA_MAX_LEN)
                     && (cnt_q[2:0] == 3'b000);
        end else begin
            len_ok = (cnt_q == TOKEN_LEN);
        end
        if (cnt_q == CNT_MAX) begin
            len_ok = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        bus.busy      = (state_q == RUN);
        bus.done      = (state_q == DONE);
        bus.crc_ok    = held_q && resid_good && len_ok;
        bus.crc_err   = held_q && !resid_good;
        bus.len_err   = held_q && !len_ok;
        bus.bit_count = cnt_q;
    end
endmodule

// File: tb/tb_usb_crc_checker.sv
module tb_usb_crc_checker;

    localparam int unsigned CW = 10;

    typedef struct {
        logic          ok;
        logic          err;
        logic          err_dc;
        logic          len;
        logic [CW-1:0] cnt;
        int unsigned   cyc;
        int unsigned   id;
    } exp_t;

    logic        clock;
    logic        reset_n;
    int unsigned cyc;
    int          n_checks;
    int          n_fail;
    int          n_done;
    int          n_pushed;
    exp_t        q[$];
    logic        stim[0:1199];

    usb_crc_checker_if #(.CW(CW)) bus ();

    usb_crc_checker #(.MAX_DATA_BYTES(64)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int unsigned id,
                                input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s pkt%0d: got %0d expected %0d", nm, id, act, req);
        end
    endfunction

    // Monitor / scoreboard: compares every done pulse with the oldest expectation
    always @(negedge clock) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            n_done++;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                e = q.pop_front();
                chk("done_cycle", e.id, cyc, e.cyc);
                chk("crc_ok", e.id, 32'(bus.crc_ok), 32'(e.ok));
                if (!e.err_dc) chk("crc_err", e.id, 32'(bus.crc_err), 32'(e.err));
                chk("len_err", e.id, 32'(bus.len_err), 32'(e.len));
                chk("bit_count", e.id, 32'(bus.bit_count), 32'(e.cnt));
                chk("busy_at_done", e.id, 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.in_bit    = 1'b0;
        bus.pkt_end   = 1'b0;
    endtask

    task automatic push_exp(input exp_t e);
        // pkt_end is sampled on the coming edge; done is visible one cycle later
        e.cyc = cyc + 1;
        q.push_back(e);
        n_pushed++;
    endtask

    // Sends stim[0..n-1]; start rides with bit 0. gap idle cycles between bits.
    // sep_end puts pkt_end in its own cycle after the last bit.
    task automatic send(input bit is_d, input int unsigned n, input int unsigned gap,
                        input bit sep_end, input bit do_end, input exp_t e);
        for (int unsigned i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int unsigned g = 0; g < gap; g++) begin
                    idle_inputs();
                    step();
                end
            end
            bus.start     = (i == 0);
            bus.is_data   = is_d;
            bus.bit_valid = 1'b1;
            bus.in_bit    = stim[i];
            bus.pkt_end   = do_end && !sep_end && (i == n - 1);
            if (bus.pkt_end) push_exp(e);
            step();
        end
        if (do_end && sep_end) begin
            idle_inputs();
            bus.pkt_end = 1'b1;
            push_exp(e);
            step();
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic load_token_setup();
        for (int i = 0; i < 1200; i++) stim[i] = 1'b0;
        stim[12] = 1'b1;   // CRC5 field 5'b00010 sent LSB-first: 0,1,0,0,0
    endtask

    task automatic load_zero();
        for (int i = 0; i < 1200; i++) stim[i] = 1'b0;
    endtask

    function automatic exp_t mk(input logic ok, input logic err, input logic dc,
                                input logic len, input int unsigned cnt, input int unsigned id);
        exp_t e;
        e.ok = ok; e.err = err; e.err_dc = dc; e.len = len;
        e.cnt = CW'(cnt); e.cyc = 0; e.id = id;
        return e;
    endfunction

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0; n_done = 0; n_pushed = 0;
        bus.is_data = 1'b0;
        idle_inputs();
        reset_n = 1'b0;
        repeat (3) step();

        chk("reset_busy", 0, 32'(bus.busy), 32'd0);
        chk("reset_done", 0, 32'(bus.done), 32'd0);
        chk("reset_crc_ok", 0, 32'(bus.crc_ok), 32'd0);
        chk("reset_crc_err", 0, 32'(bus.crc_err), 32'd0);
        chk("reset_len_err", 0, 32'(bus.len_err), 32'd0);
        chk("reset_bit_count", 0, 32'(bus.bit_count), 32'd0);

        reset_n = 1'b1;
        step();

        // Stray pkt_end / bit_valid in IDLE: nothing happens
        bus.bit_valid = 1'b1; bus.pkt_end = 1'b1;
        step(); step();
        idle_inputs();
        chk("idle_ignore_busy", 0, 32'(bus.busy), 32'd0);
        chk("idle_ignore_count", 0, 32'(bus.bit_count), 32'd0);

        // 1: SETUP token addr 0 ep 0
        load_token_setup();
        send(1'b0, 16, 0, 1'b0, 1'b1, mk(1, 0, 0, 0, 16, 1));
        // 2: zero-length DATA0
        load_zero();
        send(1'b1, 16, 0, 1'b0, 1'b1, mk(1, 0, 0, 0, 16, 2));
        // 3: token with bit 3 flipped
        load_token_setup();
        stim[3] = 1'b1;
        send(1'b0, 16, 0, 1'b0, 1'b1, mk(0, 1, 0, 0, 16, 3));
        // 4a: token cut at 15 bits (LFSR holds 00110, not the residual)
        load_token_setup();
        send(1'b0, 15, 0, 1'b0, 1'b1, mk(0, 1, 0, 1, 15, 4));
        // 4b: 65-byte data payload
        load_zero();
        send(1'b1, 16 + 8 * 65, 0, 1'b0, 1'b1, mk(0, 0, 1, 1, 536, 5));
        // Saturation of the bit counter forces len_err
        send(1'b1, 1100, 0, 1'b0, 1'b1, mk(0, 0, 1, 1, 1023, 6));
        // Zero stream checked as a token: residual 00001, length legal
        load_zero();
        send(1'b0, 16, 0, 1'b0, 1'b1, mk(0, 1, 0, 0, 16, 7));
        // 5: abort after 7 bits, then a full SETUP token; one done pulse only
        load_token_setup();
        send(1'b0, 7, 0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0));
        chk("abort_busy", 8, 32'(bus.busy), 32'd1);
        chk("abort_count", 8, 32'(bus.bit_count), 32'd7);
        send(1'b0, 16, 0, 1'b0, 1'b1, mk(1, 0, 0, 0, 16, 8));
        // pkt_end in its own cycle with no bit
        send(1'b0, 16, 0, 1'b1, 1'b1, mk(1, 0, 0, 0, 16, 9));

        // 6: reset mid-packet
        load_zero();
        send(1'b1, 8, 0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0));
        chk("pre_reset_busy", 10, 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_busy", 10, 32'(bus.busy), 32'd0);
        chk("mid_reset_count", 10, 32'(bus.bit_count), 32'd0);
        chk("mid_reset_flags", 10, {29'd0, bus.crc_ok, bus.crc_err, bus.len_err}, 32'd0);
        step(); step();
        reset_n = 1'b1;
        step();
        // Case 2 with gaps in bit_valid and a separate pkt_end cycle
        send(1'b1, 16, 2, 1'b1, 1'b1, mk(1, 0, 0, 0, 16, 11));

        repeat (5) step();
        chk("queue_drained", 99, q.size(), 32'd0);
        chk("done_pulses", 99, n_done, n_pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
